// File: rtl/bypass_pipe.sv
// Purpose : tracks register writes in flight through stages E..W and forwards the youngest ready result to each read port.
// Latency : forwarding mux and stall are combinational; the stage tracker advances one stage per clk.
// Backpress: stall asks decode to hold when the youngest matching write is not ready yet; a bubble enters stage 1 meanwhile.
module bypass_pipe #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int NRD   = 2,
    parameter int SW    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   iss_valid,
    input  logic [AW-1:0]          iss_dst,
    input  logic [SW-1:0]          iss_lat,
    input  logic                   flush,
    input  logic [NRD*AW-1:0]      rd_addr,
    input  logic [NRD*WIDTH-1:0]   rf_data,
    input  logic [DEPTH*WIDTH-1:0] stg_data,
    output logic [NRD*WIDTH-1:0]   rd_data,
    output logic [NRD*SW-1:0]      rd_sel,
    output logic                   stall,
    output logic [DEPTH-1:0]       stg_valid
);

    // Largest countdown that still lets the result become ready before it retires.
    localparam logic [SW-1:0] MAX_CNT = SW'(DEPTH - 1);

    // Index 0 is stage 1 (E), index DEPTH-1 is stage DEPTH (W).
    logic [DEPTH-1:0]         r_vld;
    logic [DEPTH-1:0][AW-1:0] r_dst;
    logic [DEPTH-1:0][SW-1:0] r_cnt;

    logic                     w_load;
    logic [SW-1:0]            w_lat;
    logic [DEPTH-1:0][SW-1:0] w_cnt_dec;
    logic [NRD-1:0]           w_hit;
    logic [NRD-1:0]           w_stall_req;

    // Decide what enters stage 1: a tracked write only when decode really advances and the target is not x0.
    always_comb begin
        w_load = iss_valid && !stall && !flush && (iss_dst != '0);
        w_lat  = (iss_lat > MAX_CNT) ? MAX_CNT : iss_lat;
    end

    // Saturating countdown applied as each entry moves to the next stage.
    always_comb begin
        w_cnt_dec = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_cnt_dec[k] = (r_cnt[k] == '0) ? '0 : (r_cnt[k] - SW'(1));
        end
    end

    // Stage tracker: shifts every cycle with no hold; the entry leaving stage DEPTH is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
            r_dst <= '0;
            r_cnt <= '0;
        end else begin
            r_vld[0] <= w_load;
            r_dst[0] <= w_load ? iss_dst : '0;
            r_cnt[0] <= w_load ? w_lat : '0;
            for (int k = 1; k < DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_dst[k] <= r_dst[k-1];
                r_cnt[k] <= w_cnt_dec[k-1];
            end
        end
    end

    // Per-port forwarding: the youngest matching stage wins; if it is not ready, read the RF and request a stall.
    always_comb begin
        rd_data     = rf_data;
        rd_sel      = '0;
        w_hit       = '0;
        w_stall_req = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!w_hit[p] && r_vld[k] && (rd_addr[p*AW +: AW] != '0)
                        && (r_dst[k] == rd_addr[p*AW +: AW])) begin
                    w_hit[p] = 1'b1;
                    if (r_cnt[k] == '0) begin
                        rd_sel[p*SW +: SW]       = SW'(k + 1);
                        rd_data[p*WIDTH +: WIDTH] = stg_data[k*WIDTH +: WIDTH];
                    end else begin
                        w_stall_req[p] = 1'b1;
                    end
                end
            end
        end
    end

    // Any port waiting on an unready producer holds decode; deliberately not qualified by iss_valid.
    always_comb begin
        stall     = |w_stall_req;
        stg_valid = r_vld;
    end

endmodule

// File: tb/tb_bypass_pipe.sv
// Purpose : directed self-checking bench for bypass_pipe with default parameters.
// Latency : inputs driven 1 ns after posedge, outputs sampled after settling, before the next edge.
// Backpress: stall is observed and decode inputs are held by the sequence while it is asserted.
module tb_bypass_pipe;

    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 3;
    localparam int NRD   = 2;
    localparam int SW    = 2;

    logic                   clk;
    logic                   reset;
    logic                   iss_valid;
    logic [AW-1:0]          iss_dst;
    logic [SW-1:0]          iss_lat;
    logic                   flush;
    logic [NRD*AW-1:0]      rd_addr;
    logic [NRD*WIDTH-1:0]   rf_data;
    logic [DEPTH*WIDTH-1:0] stg_data;
    logic [NRD*WIDTH-1:0]   rd_data;
    logic [NRD*SW-1:0]      rd_sel;
    logic                   stall;
    logic [DEPTH-1:0]       stg_valid;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] RF0 = 32'hAAAA_0000;
    localparam logic [31:0] RF1 = 32'hBBBB_0000;
    localparam logic [31:0] S1  = 32'h0000_1234;
    localparam logic [31:0] S2  = 32'h0000_2222;
    localparam logic [31:0] S3  = 32'h0000_3333;

    bypass_pipe #(
        .WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH), .NRD(NRD), .SW(SW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .iss_valid(iss_valid),
        .iss_dst(iss_dst),
        .iss_lat(iss_lat),
        .flush(flush),
        .rd_addr(rd_addr),
        .rf_data(rf_data),
        .stg_data(stg_data),
        .rd_data(rd_data),
        .rd_sel(rd_sel),
        .stall(stall),
        .stg_valid(stg_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [AW-1:0] d, input logic [SW-1:0] l);
        iss_valid = v;
        iss_dst   = d;
        iss_lat   = l;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        reset    = 1'b0;
        issue(1'b0, '0, '0);
        flush    = 1'b0;
        rd(5'd8, 5'd9);
        rf_data  = {RF1, RF0};
        stg_data = {S3, S2, S1};

        // Reset state
        #12;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_stg_valid", 32'(stg_valid), 32'd0);
        chk("rst_rd_sel", 32'(rd_sel), 32'd0);
        chk("rst_rd_data0", rd_data[31:0], RF0);
        chk("rst_rd_data1", rd_data[63:32], RF1);
        @(posedge clk);
        #1 reset = 1'b1;
        rd(5'd0, 5'd0);

        // ALU back-to-back, then follow the entry to retirement
        issue(1'b1, 5'd8, 2'd0);
        #1 chk("alu_issue_stall", 32'(stall), 32'd0);
        tick();
        issue(1'b0, '0, '0);
        rd(5'd8, 5'd0);
        #1;
        chk("alu_stg_valid", 32'(stg_valid), 32'b001);
        chk("alu_sel0", 32'(rd_sel[1:0]), 32'd1);
        chk("alu_data0", rd_data[31:0], S1);
        chk("alu_stall", 32'(stall), 32'd0);
        tick();
        chk("alu_s2_sel0", 32'(rd_sel[1:0]), 32'd2);
        chk("alu_s2_data0", rd_data[31:0], S2);
        tick();
        chk("alu_s3_sel0", 32'(rd_sel[1:0]), 32'd3);
        chk("alu_s3_data0", rd_data[31:0], S3);
        tick();
        chk("retire_sel0", 32'(rd_sel[1:0]), 32'd0);
        chk("retire_data0", rd_data[31:0], RF0);
        chk("retire_stg_valid", 32'(stg_valid), 32'd0);

        // Load-use: one stall cycle, bubble in stage 1, then forward from stage 2
        rd(5'd0, 5'd0);
        issue(1'b1, 5'd9, 2'd1);
        tick();
        issue(1'b1, 5'd10, 2'd0);
        rd(5'd0, 5'd9);
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_stall_sel1", 32'(rd_sel[3:2]), 32'd0);
        chk("lu_stall_data1", rd_data[63:32], RF1);
        tick();
        chk("lu_bubble_vld", 32'(stg_valid), 32'b010);
        chk("lu_fwd_stall", 32'(stall), 32'd0);
        chk("lu_fwd_sel1", 32'(rd_sel[3:2]), 32'd2);
        chk("lu_fwd_data1", rd_data[63:32], S2);
        tick();
        chk("lu_adv_vld", 32'(stg_valid), 32'b101);
        issue(1'b0, '0, '0);
        rd(5'd0, 5'd0);
        tick(); tick(); tick();
        chk("lu_drain_vld", 32'(stg_valid), 32'd0);

        // Latency clamp: lat=3 saturates to DEPTH-1, ready exactly in stage DEPTH
        issue(1'b1, 5'd4, 2'd3);
        tick();
        issue(1'b0, '0, '0);
        rd(5'd4, 5'd0);
        #1 chk("sat_s1_stall", 32'(stall), 32'd1);
        tick();
        chk("sat_s2_stall", 32'(stall), 32'd1);
        tick();
        chk("sat_s3_stall", 32'(stall), 32'd0);
        chk("sat_s3_sel0", 32'(rd_sel[1:0]), 32'd3);
        chk("sat_s3_data0", rd_data[31:0], S3);
        tick();
        chk("sat_retired", 32'(stg_valid), 32'd0);

        // Priority: youngest matching stage wins
        rd(5'd0, 5'd0);
        stg_data = {S3, 32'h0000_000B, 32'h0000_000A};
        issue(1'b1, 5'd5, 2'd0);
        tick();
        tick();
        issue(1'b0, '0, '0);
        rd(5'd0, 5'd5);
        #1;
        chk("prio_sel1", 32'(rd_sel[3:2]), 32'd1);
        chk("prio_data1", rd_data[63:32], 32'h0000_000A);
        rd(5'd0, 5'd0);
        tick(); tick(); tick();
        stg_data = {S3, S2, S1};

        // Register zero is never tracked
        issue(1'b1, 5'd0, 2'd0);
        tick();
        issue(1'b0, '0, '0);
        rd(5'd0, 5'd0);
        #1;
        chk("x0_stg_valid0", 32'(stg_valid[0]), 32'd0);
        chk("x0_sel0", 32'(rd_sel[1:0]), 32'd0);
        chk("x0_data0", rd_data[31:0], RF0);

        // Flush cancels the decode-stage instruction
        issue(1'b1, 5'd7, 2'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        issue(1'b0, '0, '0);
        rd(5'd7, 5'd0);
        #1;
        chk("flush_stg_valid0", 32'(stg_valid[0]), 32'd0);
        chk("flush_sel0", 32'(rd_sel[1:0]), 32'd0);
        chk("flush_data0", rd_data[31:0], RF0);
        rd(5'd0, 5'd0);
        tick(); tick();

        // Asynchronous reset while stalled
        issue(1'b1, 5'd9, 2'd2);
        tick();
        issue(1'b0, '0, '0);
        rd(5'd9, 5'd0);
        #1 chk("ar_pre_stall", 32'(stall), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ar_stall", 32'(stall), 32'd0);
        chk("ar_stg_valid", 32'(stg_valid), 32'd0);
        chk("ar_data0", rd_data[31:0], RF0);
        #2 reset = 1'b1;
        tick();
        chk("ar_after_stall", 32'(stall), 32'd0);
        chk("ar_after_vld", 32'(stg_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
